// File: rtl/random_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : random_seq_pkg
// Purpose  : Shared state type, sequence endpoints and successor lookup for the
//            3-bit pseudo-random sequence (7,4,1,6,2,5).
// Revision : 1.0  initial release
// ============================================================================
package random_seq_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } seq_state_t;

  localparam logic [2:0] SEQ_FIRST = 3'd7;
  localparam logic [2:0] SEQ_LAST  = 3'd5;

  // Returns {legal, next}; codes 0 and 3 never occur in the sequence.
  function automatic logic [3:0] seq_succ(input logic [2:0] val);
    logic [3:0] res;
    case (val)
      3'd7:    res = {1'b1, 3'd4};
      3'd4:    res = {1'b1, 3'd1};
      3'd1:    res = {1'b1, 3'd6};
      3'd6:    res = {1'b1, 3'd2};
      3'd2:    res = {1'b1, 3'd5};
      3'd5:    res = {1'b1, SEQ_FIRST};
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/random_seq_succ.sv
`default_nettype none
// ============================================================================
// Module   : random_seq_succ
// Purpose  : Combinational successor / legality lookup for one sequence value.
// Revision : 1.0  initial release
// ============================================================================
module random_seq_succ
  import random_seq_pkg::*;
(
  input  logic [2:0] i_val,
  output logic       o_legal,
  output logic [2:0] o_next
);

  assign {o_legal, o_next} = seq_succ(i_val);

endmodule
`default_nettype wire

// File: rtl/random_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : random_seq_checker
// Purpose  : Locks onto the generator's sequence, then flags mismatches and
//            illegal codes, counts errors and marks each completed period.
// Revision : 1.0  initial release
// ============================================================================
module random_seq_checker
  import random_seq_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       seq_in,
  output logic             locked,
  output logic [2:0]       exp_next,
  output logic             mismatch,
  output logic             illegal,
  output logic             period_done,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0]       c_lock    = 3'(LOCK_CNT);
  localparam logic [ERR_W-1:0] c_err_max = {ERR_W{1'b1}};

  seq_state_t       r_state, w_state;
  logic [2:0]       r_last, w_last;
  logic [2:0]       r_run, w_run;
  logic [2:0]       r_exp, w_exp;
  logic             r_locked;
  logic             r_mismatch, w_mismatch;
  logic             r_illegal, w_illegal;
  logic             r_period, w_period;
  logic [ERR_W-1:0] r_err, w_err;

  logic       w_last_legal, w_in_legal;
  logic [2:0] w_last_next, w_in_next;
  logic       w_match;

  random_seq_succ u_succ_last (
    .i_val   (r_last),
    .o_legal (w_last_legal),
    .o_next  (w_last_next)
  );

  random_seq_succ u_succ_in (
    .i_val   (seq_in),
    .o_legal (w_in_legal),
    .o_next  (w_in_next)
  );

  assign w_match = w_last_legal && w_in_legal && (seq_in == w_last_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_last     <= 3'd0;
      r_run      <= 3'd0;
      r_exp      <= 3'd0;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
      r_illegal  <= 1'b0;
      r_period   <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state;
      r_last     <= w_last;
      r_run      <= w_run;
      r_exp      <= w_exp;
      r_locked   <= (w_state == LOCKED);
      r_mismatch <= w_mismatch;
      r_illegal  <= w_illegal;
      r_period   <= w_period;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_last     = r_last;
    w_run      = r_run;
    w_exp      = r_exp;
    w_mismatch = 1'b0;
    w_illegal  = 1'b0;
    w_period   = 1'b0;
    w_err      = r_err;

    if (in_valid) begin
      // Every path to HUNT clears last so exp_next reads 0 there.
      case (r_state)
        HUNT: begin
          if (w_in_legal) begin
            w_state = ACQUIRE;
            w_last  = seq_in;
            w_exp   = w_in_next;
            w_run   = 3'd0;
          end else begin
            w_illegal = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!w_in_legal) begin
            w_illegal = 1'b1;
            w_state   = HUNT;
            w_last    = 3'd0;
            w_exp     = 3'd0;
            w_run     = 3'd0;
          end else if (w_match) begin
            w_last = seq_in;
            w_exp  = w_in_next;
            w_run  = r_run + 3'd1;
            if (r_run + 3'd1 == c_lock) begin
              w_state = LOCKED;
            end
          end else begin
            w_last = seq_in;
            w_exp  = w_in_next;
            w_run  = 3'd0;
          end
        end
        LOCKED: begin
          if (!w_in_legal) begin
            w_illegal  = 1'b1;
            w_mismatch = 1'b1;
            w_state    = HUNT;
            w_last     = 3'd0;
            w_exp      = 3'd0;
            w_run      = 3'd0;
          end else if (w_match) begin
            w_last   = seq_in;
            w_exp    = w_in_next;
            w_period = (seq_in == SEQ_LAST);
          end else begin
            w_mismatch = 1'b1;
            w_state    = ACQUIRE;
            w_last     = seq_in;
            w_exp      = w_in_next;
            w_run      = 3'd0;
          end
        end
        default: begin
          w_state = HUNT;
          w_last  = 3'd0;
          w_exp   = 3'd0;
          w_run   = 3'd0;
        end
      endcase

      if (w_mismatch && (r_err != c_err_max)) begin
        w_err = r_err + 1'b1;
      end
    end
  end

  assign locked      = r_locked;
  assign exp_next    = r_exp;
  assign mismatch    = r_mismatch;
  assign illegal     = r_illegal;
  assign period_done = r_period;
  assign err_count   = r_err;

endmodule
`default_nettype wire
